// File: rtl/lsb_pkg.sv
//============================================================================
// Module   : lsb_pkg
// Brief    : Shared funct3 codes, entry/FSM state encodings and mem_size
//            encodings for the load/store queue and data alignment logic.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package lsb_pkg;

   // Load funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // mem_size encodings
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   typedef enum logic [1:0] {
      E_WAIT_OPND   = 2'd0,
      E_WAIT_COMMIT = 2'd1,
      E_READY       = 2'd2
   } entry_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fsm_state_t;

   function automatic logic [1:0] size_of(input logic [2:0] op);
      logic [1:0] s;
      s = SIZE_BYTE;
      if (op == LW)
         s = SIZE_WORD;
      else if (op[1:0] == 2'b01)
         s = SIZE_HALF;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsb_data_align.sv
//============================================================================
// Module   : lsb_data_align
// Brief    : Combinational store-data masking, load-data extension and
//            access-size decode from funct3.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module lsb_data_align
   import lsb_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_raw,
   output logic [31:0] st_masked,
   output logic [31:0] ld_value,
   output logic [1:0]  size
);

   always_comb begin
      st_masked = st_data;
      case (op)
         SB:      st_masked = {24'b0, st_data[7:0]};
         SH:      st_masked = {16'b0, st_data[15:0]};
         default: st_masked = st_data;
      endcase
   end

   always_comb begin
      ld_value = ld_raw;
      case (op)
         LB:      ld_value = {{24{ld_raw[7]}}, ld_raw[7:0]};
         LBU:     ld_value = {24'b0, ld_raw[7:0]};
         LH:      ld_value = {{16{ld_raw[15]}}, ld_raw[15:0]};
         LHU:     ld_value = {16'b0, ld_raw[15:0]};
         default: ld_value = ld_raw;
      endcase
   end

   assign size = size_of(op);

endmodule

`default_nettype wire

// File: rtl/lsb_queue.sv
//============================================================================
// Module   : lsb_queue
// Brief    : In-order load/store queue: commit-gated stores, CDB broadcast of
//            load results and store acks, flush survival of committed stores.
//            Optional counters enabled by defining LSB_PERF_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module lsb_queue
   import lsb_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ROB_W = 5
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic             disp_valid,
   input  logic             disp_is_store,
   input  logic [2:0]       disp_op,
   input  logic [ROB_W-1:0] disp_rob_id,
   output logic             full_out,
   output logic             empty_out,
   input  logic             opnd_valid,
   input  logic [ROB_W-1:0] opnd_rob_id,
   input  logic [31:0]      opnd_addr,
   input  logic [31:0]      opnd_data,
   input  logic             commit_valid,
   input  logic [ROB_W-1:0] commit_rob_id,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [1:0]       mem_size,
   input  logic             mem_busy,
   input  logic             mem_done,
   input  logic [31:0]      mem_rdata,
   output logic             cdb_valid,
   output logic [ROB_W-1:0] cdb_rob_id,
   output logic [31:0]      cdb_value
`ifdef LSB_PERF_EN
   ,
   output logic [31:0]      perf_loads,
   output logic [31:0]      perf_stores,
   output logic [31:0]      perf_stall
`endif
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [IDX_W-1:0] r_head, r_tail;
   logic [CNT_W-1:0] r_count, r_ccnt;

   logic [DEPTH-1:0] r_valid, r_store, r_acked;
   entry_state_t     r_est  [DEPTH];
   logic [2:0]       r_op   [DEPTH];
   logic [ROB_W-1:0] r_rob  [DEPTH];
   logic [31:0]      r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];

   fsm_state_t r_fsm, w_fsm_next;

   logic             r_mem_req, r_mem_we;
   logic [31:0]      r_mem_addr, r_mem_wdata;
   logic [1:0]       r_mem_size;
   logic             r_cdb_valid;
   logic [ROB_W-1:0] r_cdb_rob;
   logic [31:0]      r_cdb_value;

   logic w_issue, w_pop, w_ld_done, w_st_done, w_push;
   logic w_h_ready, w_h_store;
   logic [DEPTH-1:0] w_keep, w_opnd_hit, w_commit_hit;
   logic             w_ack_hit;
   logic [IDX_W-1:0] w_ack_idx, w_scan, w_head_next;
   logic [CNT_W-1:0] w_ccnt_next;
   logic [31:0]      w_st_masked, w_ld_value;
   logic [1:0]       w_size;

   assign full_out  = (r_count == CNT_W'(DEPTH));
   assign empty_out = (r_count == '0);
   assign w_h_store = r_store[r_head];
   assign w_h_ready = r_valid[r_head] && (r_est[r_head] == E_READY);

   lsb_data_align u_align (
      .op        (r_op[r_head]),
      .st_data   (r_data[r_head]),
      .ld_raw    (mem_rdata),
      .st_masked (w_st_masked),
      .ld_value  (w_ld_value),
      .size      (w_size)
   );

   // Per-entry match and flush-survival decode; survivors are the ccnt oldest
   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_entry
         logic [IDX_W-1:0] w_off;
         assign w_off           = IDX_W'(g) - r_head;
         assign w_keep[g]       = ({1'b0, w_off} < r_ccnt);
         assign w_opnd_hit[g]   = opnd_valid && r_valid[g] &&
                                  (r_est[g] == E_WAIT_OPND) && (r_rob[g] == opnd_rob_id);
         assign w_commit_hit[g] = commit_valid && r_valid[g] && r_store[g] &&
                                  (r_est[g] == E_WAIT_COMMIT) && (r_rob[g] == commit_rob_id);
      end
   endgenerate

   // Oldest store holding operands that has not yet been acknowledged
   always_comb begin
      w_ack_hit = 1'b0;
      w_ack_idx = '0;
      w_scan    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_scan = r_head + IDX_W'(i);
         if (!w_ack_hit && r_valid[w_scan] && r_store[w_scan] && !r_acked[w_scan] &&
             (r_est[w_scan] != E_WAIT_OPND)) begin
            w_ack_hit = 1'b1;
            w_ack_idx = w_scan;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)
         r_fsm <= IDLE;
      else if (rdy_in)
         r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      w_issue    = 1'b0;
      w_pop      = 1'b0;
      w_ld_done  = 1'b0;
      w_st_done  = 1'b0;
      case (r_fsm)
         IDLE: begin
            if (w_h_ready && !mem_busy && !clear_in) begin
               w_issue    = 1'b1;
               w_fsm_next = WAIT;
            end
         end
         WAIT: begin
            if (mem_done) begin
               w_pop      = 1'b1;
               w_st_done  = w_h_store;
               w_ld_done  = !w_h_store;
               w_fsm_next = IDLE;
            end else if (clear_in && !w_h_store) begin
               w_fsm_next = DRAIN;
            end
         end
         DRAIN: begin
            if (mem_done)
               w_fsm_next = IDLE;
         end
         default: w_fsm_next = IDLE;
      endcase
   end

   assign w_push      = disp_valid && !clear_in && (!full_out || w_pop);
   assign w_head_next = r_head + IDX_W'(w_pop);
   assign w_ccnt_next = r_ccnt + CNT_W'(commit_valid && !clear_in) - CNT_W'(w_st_done);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_ccnt  <= '0;
      end else if (rdy_in) begin
         r_head <= w_head_next;
         r_ccnt <= w_ccnt_next;
         if (clear_in) begin
            r_count <= w_ccnt_next;
            r_tail  <= w_head_next + w_ccnt_next[IDX_W-1:0];
         end else begin
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_tail  <= r_tail + IDX_W'(w_push);
         end
      end
   end

   // Pop precedes push so a full queue can retire and refill one slot per cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_valid <= '0;
         r_store <= '0;
         r_acked <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_est[i]  <= E_WAIT_OPND;
            r_op[i]   <= '0;
            r_rob[i]  <= '0;
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else if (rdy_in) begin
         if (w_pop)
            r_valid[r_head] <= 1'b0;
         if (clear_in) begin
            for (int i = 0; i < DEPTH; i++)
               if (!w_keep[i])
                  r_valid[i] <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (w_opnd_hit[i]) begin
                  r_addr[i] <= opnd_addr;
                  r_data[i] <= opnd_data;
                  r_est[i]  <= r_store[i] ? E_WAIT_COMMIT : E_READY;
               end
               if (w_commit_hit[i])
                  r_est[i] <= E_READY;
            end
            if (w_ack_hit && !w_ld_done)
               r_acked[w_ack_idx] <= 1'b1;
            if (w_push) begin
               r_valid[r_tail] <= 1'b1;
               r_store[r_tail] <= disp_is_store;
               r_acked[r_tail] <= 1'b0;
               r_op[r_tail]    <= disp_op;
               r_rob[r_tail]   <= disp_rob_id;
               r_est[r_tail]   <= E_WAIT_OPND;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_size  <= '0;
      end else if (rdy_in) begin
         r_mem_req <= w_issue;
         if (w_issue) begin
            r_mem_we    <= w_h_store;
            r_mem_addr  <= r_addr[r_head];
            r_mem_wdata <= w_h_store ? w_st_masked : 32'b0;
            r_mem_size  <= w_size;
         end
      end
   end

   // Load results win the CDB; a pending store ack simply waits a cycle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_cdb_valid <= 1'b0;
         r_cdb_rob   <= '0;
         r_cdb_value <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            r_cdb_valid <= 1'b0;
         end else if (w_ld_done) begin
            r_cdb_valid <= 1'b1;
            r_cdb_rob   <= r_rob[r_head];
            r_cdb_value <= w_ld_value;
         end else if (w_ack_hit) begin
            r_cdb_valid <= 1'b1;
            r_cdb_rob   <= r_rob[w_ack_idx];
            r_cdb_value <= 32'b0;
         end else begin
            r_cdb_valid <= 1'b0;
         end
      end
   end

   assign mem_req    = r_mem_req & rdy_in;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_size   = r_mem_size;
   assign cdb_valid  = r_cdb_valid & rdy_in;
   assign cdb_rob_id = r_cdb_rob;
   assign cdb_value  = r_cdb_value;

`ifdef LSB_PERF_EN
   logic [31:0] r_perf_loads, r_perf_stores, r_perf_stall;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_perf_loads  <= '0;
         r_perf_stores <= '0;
         r_perf_stall  <= '0;
      end else if (rdy_in) begin
         if (w_ld_done)
            r_perf_loads <= r_perf_loads + 32'd1;
         if (w_st_done)
            r_perf_stores <= r_perf_stores + 32'd1;
         if ((r_fsm == IDLE) && w_h_ready && mem_busy)
            r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_loads  = r_perf_loads;
   assign perf_stores = r_perf_stores;
   assign perf_stall  = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsb_queue.sv
//============================================================================
// Module   : tb_lsb_queue
// Brief    : Directed self-checking bench for lsb_queue.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_lsb_queue;
   import lsb_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_in;
   logic        disp_valid, disp_is_store;
   logic [2:0]  disp_op;
   logic [4:0]  disp_rob_id;
   logic        full_out, empty_out;
   logic        opnd_valid;
   logic [4:0]  opnd_rob_id;
   logic [31:0] opnd_addr, opnd_data;
   logic        commit_valid;
   logic [4:0]  commit_rob_id;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_busy, mem_done;
   logic [31:0] mem_rdata;
   logic        cdb_valid;
   logic [4:0]  cdb_rob_id;
   logic [31:0] cdb_value;
`ifdef LSB_PERF_EN
   logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   lsb_queue #(.DEPTH(16), .ROB_W(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_op(disp_op),
      .disp_rob_id(disp_rob_id), .full_out(full_out), .empty_out(empty_out),
      .opnd_valid(opnd_valid), .opnd_rob_id(opnd_rob_id), .opnd_addr(opnd_addr),
      .opnd_data(opnd_data), .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
`ifdef LSB_PERF_EN
      , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
`endif
   );

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic dispatch(input logic st, input logic [2:0] op, input logic [4:0] rob);
      disp_valid = 1'b1; disp_is_store = st; disp_op = op; disp_rob_id = rob;
      tick();
      disp_valid = 1'b0;
   endtask

   task automatic operand(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] data);
      opnd_valid = 1'b1; opnd_rob_id = rob; opnd_addr = addr; opnd_data = data;
      tick();
      opnd_valid = 1'b0;
   endtask

   task automatic commit(input logic [4:0] rob);
      commit_valid = 1'b1; commit_rob_id = rob;
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [4:0] rob, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp_val, input logic [1:0] exp_size);
      dispatch(1'b0, op, rob);
      operand(rob, addr, 32'h0);
      chk({tag, "_req_pre"}, 32'(mem_req), 32'd0);
      tick();
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_addr"}, mem_addr, addr);
      chk({tag, "_size"}, 32'(mem_size), 32'(exp_size));
      mem_done = 1'b1; mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
      chk({tag, "_req_pulse"}, 32'(mem_req), 32'd0);
      chk({tag, "_cdb_v"}, 32'(cdb_valid), 32'd1);
      chk({tag, "_cdb_rob"}, 32'(cdb_rob_id), 32'(rob));
      chk({tag, "_cdb_val"}, cdb_value, exp_val);
      tick();
      chk({tag, "_cdb_off"}, 32'(cdb_valid), 32'd0);
      chk({tag, "_empty"}, 32'(empty_out), 32'd1);
   endtask

   initial begin
      int k;
      logic [4:0] exp_rob;
      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
      disp_valid = 1'b0; disp_is_store = 1'b0; disp_op = '0; disp_rob_id = '0;
      opnd_valid = 1'b0; opnd_rob_id = '0; opnd_addr = '0; opnd_data = '0;
      commit_valid = 1'b0; commit_rob_id = '0;
      mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      tick(); tick();
      rst_in = 1'b0;

      chk("rst_empty", 32'(empty_out), 32'd1);
      chk("rst_full", 32'(full_out), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_cdb", 32'(cdb_valid), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);

      // Loads with sign and zero extension
      do_load("lb", 5'd3, LB, 32'h100, 32'h0000_00F0, 32'hFFFF_FFF0, SIZE_BYTE);
      do_load("lhu", 5'd5, LHU, 32'h104, 32'h0000_8001, 32'h0000_8001, SIZE_HALF);

      // Store waits for commit; ack broadcast with value 0
      dispatch(1'b1, SW, 5'd4);
      operand(5'd4, 32'h200, 32'hDEAD_BEEF);
      chk("sw_no_req0", 32'(mem_req), 32'd0);
      tick();
      chk("sw_ack_v", 32'(cdb_valid), 32'd1);
      chk("sw_ack_rob", 32'(cdb_rob_id), 32'd4);
      chk("sw_ack_val", cdb_value, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sw_no_req", 32'(mem_req), 32'd0);
         chk("sw_ack_once", 32'(cdb_valid), 32'd0);
      end
      commit(5'd4);
      tick();
      chk("sw_req", 32'(mem_req), 32'd1);
      chk("sw_we", 32'(mem_we), 32'd1);
      chk("sw_addr", mem_addr, 32'h200);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_size", 32'(mem_size), 32'(SIZE_WORD));
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("sw_empty", 32'(empty_out), 32'd1);
      chk("sw_no_cdb", 32'(cdb_valid), 32'd0);

      // Fill, overflow ignored, pop+push while full, tail wrap
      for (int i = 0; i < 16; i++)
         dispatch(1'b0, LW, 5'(i));
      chk("fill_full", 32'(full_out), 32'd1);
      dispatch(1'b0, LW, 5'd20);
      chk("ovf_full", 32'(full_out), 32'd1);
      operand(5'd0, 32'h300, 32'h0);
      tick();
      chk("fill_req", 32'(mem_req), 32'd1);
      mem_done = 1'b1; mem_rdata = 32'h11;
      disp_valid = 1'b1; disp_is_store = 1'b0; disp_op = LW; disp_rob_id = 5'd21;
      tick();
      mem_done = 1'b0; disp_valid = 1'b0;
      chk("pp_full", 32'(full_out), 32'd1);
      chk("pp_cdb_rob", 32'(cdb_rob_id), 32'd0);
      chk("pp_cdb_val", cdb_value, 32'h11);
      for (int i = 1; i < 16; i++)
         operand(5'(i), 32'h1000 + 32'(i) * 4, 32'h0);
      operand(5'd21, 32'h2000, 32'h0);
      mem_done = 1'b1; mem_rdata = 32'h0000_AAAA;
      k = 0;
      for (int c = 0; c < 100 && k < 16; c++) begin
         tick();
         if (cdb_valid) begin
            exp_rob = (k < 15) ? 5'(k + 1) : 5'd21;
            chk("drain_rob", 32'(cdb_rob_id), 32'(exp_rob));
            k++;
         end
      end
      mem_done = 1'b0;
      chk("drain_cnt", 32'(k), 32'd16);
      chk("drain_empty", 32'(empty_out), 32'd1);

      // Clear keeps only the committed SB
      mem_busy = 1'b1;
      dispatch(1'b1, SB, 5'd6);
      operand(5'd6, 32'h40, 32'h1234_5678);
      tick();
      chk("sb_ack_v", 32'(cdb_valid), 32'd1);
      chk("sb_ack_rob", 32'(cdb_rob_id), 32'd6);
      commit(5'd6);
      dispatch(1'b0, LW, 5'd7);
      dispatch(1'b0, LW, 5'd8);
      dispatch(1'b0, LW, 5'd9);
      operand(5'd7, 32'h80, 32'h0);
      chk("busy_no_req", 32'(mem_req), 32'd0);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("clr_keep", 32'(empty_out), 32'd0);
      mem_busy = 1'b0;
      tick();
      chk("clr_sb_req", 32'(mem_req), 32'd1);
      chk("clr_sb_we", 32'(mem_we), 32'd1);
      chk("clr_sb_addr", mem_addr, 32'h40);
      chk("clr_sb_wdata", mem_wdata, 32'h0000_0078);
      chk("clr_sb_size", 32'(mem_size), 32'(SIZE_BYTE));
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("clr_count1", 32'(empty_out), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_no_req", 32'(mem_req), 32'd0);
         chk("clr_no_cdb", 32'(cdb_valid), 32'd0);
      end

      // Clear with a load in flight: its completion is swallowed
      dispatch(1'b0, LW, 5'd10);
      operand(5'd10, 32'h500, 32'h0);
      tick();
      chk("drn_req", 32'(mem_req), 32'd1);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      chk("drn_empty", 32'(empty_out), 32'd1);
      mem_done = 1'b1; mem_rdata = 32'h55;
      tick();
      mem_done = 1'b0;
      chk("drn_no_cdb", 32'(cdb_valid), 32'd0);
      tick();
      chk("drn_no_cdb2", 32'(cdb_valid), 32'd0);
      do_load("post_drn", 5'd11, LBU, 32'h508, 32'h0000_0080, 32'h0000_0080, SIZE_BYTE);

      // Load result beats a concurrently eligible store ack
      dispatch(1'b0, LW, 5'd12);
      dispatch(1'b1, SW, 5'd13);
      operand(5'd12, 32'h600, 32'h0);
      operand(5'd13, 32'h604, 32'hCAFE_F00D);
      chk("prio_req", 32'(mem_req), 32'd1);
      mem_done = 1'b1; mem_rdata = 32'h7777_7777;
      tick();
      mem_done = 1'b0;
      chk("prio_ld_rob", 32'(cdb_rob_id), 32'd12);
      chk("prio_ld_val", cdb_value, 32'h7777_7777);
      tick();
      chk("prio_ack_v", 32'(cdb_valid), 32'd1);
      chk("prio_ack_rob", 32'(cdb_rob_id), 32'd13);
      chk("prio_ack_val", cdb_value, 32'h0);
      commit(5'd13);
      tick();
      chk("prio_sw_wdata", mem_wdata, 32'hCAFE_F00D);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("prio_empty", 32'(empty_out), 32'd1);

      // rdy_in low freezes a load in WAIT; held mem_done completes it later
      dispatch(1'b0, LH, 5'd14);
      operand(5'd14, 32'h700, 32'h0);
      tick();
      chk("rdy_req", 32'(mem_req), 32'd1);
      chk("rdy_size", 32'(mem_size), 32'(SIZE_HALF));
      rdy_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            mem_done = 1'b1; mem_rdata = 32'h0000_F00F;
         end
         tick();
         chk("frz_req", 32'(mem_req), 32'd0);
         chk("frz_cdb", 32'(cdb_valid), 32'd0);
         chk("frz_empty", 32'(empty_out), 32'd0);
      end
      rdy_in = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("rdy_cdb_v", 32'(cdb_valid), 32'd1);
      chk("rdy_cdb_rob", 32'(cdb_rob_id), 32'd14);
      chk("rdy_cdb_val", cdb_value, 32'hFFFF_F00F);
      tick();
      chk("rdy_empty", 32'(empty_out), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
